// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the CNN layer sequencer: FSM encoding, accelerator
// register map, descriptor field layout and the per-layer weight address step.
package cnn_seq_pkg;

  typedef logic [3:0] seq_state_t;

  localparam seq_state_t S_IDLE    = 4'd0;
  localparam seq_state_t S_WR_BASE = 4'd1;
  localparam seq_state_t S_WR_CFG  = 4'd2;
  localparam seq_state_t S_WR_ST1  = 4'd3;
  localparam seq_state_t S_WR_ST0  = 4'd4;
  localparam seq_state_t S_WAIT    = 4'd5;
  localparam seq_state_t S_ADV     = 4'd6;
  localparam seq_state_t S_FIN     = 4'd7;
  localparam seq_state_t S_ERR     = 4'd8;

  localparam int REG_BASE_ADDRESS = 0;
  localparam int REG_LAYER_CONFIG = 1;
  localparam int REG_LAYER_START  = 2;

  // Descriptor word is {is_conv3x3, bias_shift[4:0], act_shift[2:0]}
  localparam int DESC_W        = 9;
  localparam int DESC_ACT_LSB  = 0;
  localparam int DESC_ACT_W    = 3;
  localparam int DESC_BIAS_LSB = 3;
  localparam int DESC_BIAS_W   = 5;
  localparam int DESC_CONV_BIT = 8;

  function automatic int weight_step(input int t_in, input int t_out, input int n_words);
    return (t_in * t_out * 9) / n_words;
  endfunction

endpackage

// File: rtl/cnn_seq_desc_ram.sv
// Layer descriptor table: register file with one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module cnn_seq_desc_ram
  import cnn_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W_IDX = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [W_IDX-1:0]  waddr,
  input  logic [DESC_W-1:0] wdata,
  input  logic [W_IDX-1:0]  raddr,
  output logic [DESC_W-1:0] rdata
);

  logic [DESC_W-1:0] mem_q [DEPTH];
  logic [DESC_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Descriptor-driven layer sequencer: programs the accelerator register port for
// each layer, waits for layer_done and steps the weight/param base addresses.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int N_LAYER_MAX    = 8,
  parameter int W_LIDX         = $clog2(N_LAYER_MAX),
  parameter int Ti             = 16,
  parameter int To             = 16,
  parameter int N              = 16,
  parameter int W_BASE_W       = 20,
  parameter int W_BASE_P       = 12,
  parameter int W_RADDR        = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int W_TO           = 24
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                cfg_we,
  input  logic [W_LIDX-1:0]   cfg_idx,
  input  logic [8:0]          cfg_wdata,
  input  logic [W_LIDX:0]     cfg_n_layers,
  input  logic [W_BASE_W-1:0] cfg_base_weight,
  input  logic [W_BASE_P-1:0] cfg_base_param,
  input  logic                start,
  input  logic                abort,
  output logic                reg_req,
  output logic [W_RADDR-1:0]  reg_addr,
  output logic [31:0]         reg_wdata,
  input  logic                reg_ack,
  input  logic                layer_done,
  output logic                busy,
  output logic [W_LIDX-1:0]   cur_layer,
  output logic                seq_done,
  output logic                error
);

  localparam logic [W_BASE_W-1:0] W_STEP_CONV  = W_BASE_W'(weight_step(Ti, To, N));
  localparam logic [W_BASE_W-1:0] W_STEP_OTHER = W_BASE_W'(To);
  localparam logic [W_BASE_P-1:0] P_STEP       = W_BASE_P'(To);
  localparam logic [W_LIDX:0]     N_MAX_L      = (W_LIDX+1)'(N_LAYER_MAX);
  localparam logic [W_LIDX:0]     ONE_L        = (W_LIDX+1)'(1);
  localparam logic [W_TO-1:0]     TO_LAST      = W_TO'(TIMEOUT_CYCLES - 1);
  localparam logic [W_TO-1:0]     TO_ONE       = W_TO'(1);

  seq_state_t          state_q, state_d;
  logic                req_q, req_d;
  logic [W_LIDX-1:0]   cur_q, cur_d;
  logic [W_LIDX:0]     n_layers_q, n_layers_d;
  logic [W_BASE_W-1:0] wbase_q, wbase_d;
  logic [W_BASE_P-1:0] pbase_q, pbase_d;
  logic [W_TO-1:0]     to_cnt_q, to_cnt_d;
  logic                err_q, err_d;

  logic [DESC_W-1:0]   desc;
  logic                is_first, is_last, is_conv;
  logic [15:0]         cfg_word;

  cnn_seq_desc_ram #(
    .DEPTH (N_LAYER_MAX),
    .W_IDX (W_LIDX)
  ) u_desc_ram (
    .clk   (HCLK),
    .we    (cfg_we & ~busy),
    .waddr (cfg_idx),
    .wdata (cfg_wdata),
    .raddr (cur_q),
    .rdata (desc)
  );

  assign is_first = (cur_q == '0);
  assign is_last  = ({1'b0, cur_q} == (n_layers_q - ONE_L));
  assign is_conv  = desc[DESC_CONV_BIT];
  assign cfg_word = {desc[DESC_ACT_LSB +: DESC_ACT_W], desc[DESC_BIAS_LSB +: DESC_BIAS_W],
                     4'(cur_q), is_last, is_conv, is_last, is_first};

  // Request is raised one cycle after entering a write state, so every ack is
  // followed by at least one idle cycle on reg_req before the next write.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cur_d      = cur_q;
    n_layers_d = n_layers_q;
    wbase_d    = wbase_q;
    pbase_d    = pbase_q;
    to_cnt_d   = to_cnt_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          err_d      = 1'b0;
          wbase_d    = cfg_base_weight;
          pbase_d    = cfg_base_param;
          cur_d      = '0;
          n_layers_d = cfg_n_layers;
          if (cfg_n_layers == '0) begin
            state_d = S_FIN;
          end else if (cfg_n_layers > N_MAX_L) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_WR_BASE;
          end
        end
      end
      S_WR_BASE, S_WR_CFG, S_WR_ST1, S_WR_ST0: begin
        if (req_q && reg_ack) begin
          req_d = 1'b0;
          case (state_q)
            S_WR_BASE: state_d = S_WR_CFG;
            S_WR_CFG:  state_d = S_WR_ST1;
            S_WR_ST1:  state_d = S_WR_ST0;
            default: begin
              state_d  = S_WAIT;
              to_cnt_d = '0;
            end
          endcase
        end else begin
          req_d = 1'b1;
        end
      end
      S_WAIT: begin
        to_cnt_d = to_cnt_q + TO_ONE;
        if (layer_done) begin
          state_d = S_ADV;
        end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_ADV: begin
        wbase_d = wbase_q + (is_conv ? W_STEP_CONV : W_STEP_OTHER);
        pbase_d = pbase_q + P_STEP;
        if (is_last) begin
          state_d = S_FIN;
        end else begin
          cur_d   = cur_q + 1'b1;
          state_d = S_WR_BASE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides any handshake or done event seen in the same cycle
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      cur_q      <= '0;
      n_layers_q <= '0;
      wbase_q    <= '0;
      pbase_q    <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cur_q      <= cur_d;
      n_layers_q <= n_layers_d;
      wbase_q    <= wbase_d;
      pbase_q    <= pbase_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    reg_addr  = '0;
    reg_wdata = '0;
    case (state_q)
      S_WR_BASE: begin
        reg_addr  = W_RADDR'(REG_BASE_ADDRESS);
        reg_wdata = 32'({pbase_q, wbase_q});
      end
      S_WR_CFG: begin
        reg_addr  = W_RADDR'(REG_LAYER_CONFIG);
        reg_wdata = {16'h0000, cfg_word};
      end
      S_WR_ST1: begin
        reg_addr  = W_RADDR'(REG_LAYER_START);
        reg_wdata = 32'd1;
      end
      S_WR_ST0: begin
        reg_addr  = W_RADDR'(REG_LAYER_START);
        reg_wdata = 32'd0;
      end
      default: ;
    endcase
  end

  assign reg_req   = req_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign seq_done  = (state_q == S_FIN);
  assign error     = err_q;
  assign cur_layer = cur_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: scripted register-port responder plus
// per-scenario tasks comparing observed writes and flags to hand-computed values.
module tb_cnn_layer_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [8:0]  cfg_wdata;
  logic [3:0]  cfg_n_layers;
  logic [19:0] cfg_base_weight;
  logic [11:0] cfg_base_param;
  logic        start, abort;
  logic        reg_req;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ack, layer_done;
  logic        busy;
  logic [2:0]  cur_layer;
  logic        seq_done, error;

  int n_vec  = 0;
  int n_miss = 0;

  logic [1:0]  wr_addr [64];
  logic [31:0] wr_data [64];
  int  wr_cnt, done_pulses, seq_obs, unstable, gap_viol, req_len_min, req_len_max;
  int  req_obs_total, wait_entry_obs, err_obs, busy_low_obs, last_done_obs;
  logic post_req, post_busy, err_obs1;
  bit  timed_out;

  cnn_layer_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_wdata(cfg_wdata), .cfg_n_layers(cfg_n_layers), .cfg_base_weight(cfg_base_weight),
    .cfg_base_param(cfg_base_param), .start(start), .abort(abort), .reg_req(reg_req),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ack(reg_ack), .layer_done(layer_done),
    .busy(busy), .cur_layer(cur_layer), .seq_done(seq_done), .error(error)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic load_desc(input int idx, input int bias, input int act, input bit conv);
    cfg_we    = 1'b1;
    cfg_idx   = 3'(idx);
    cfg_wdata = {conv, 5'(bias), 3'(act)};
    tick(1);
    cfg_we    = 1'b0;
  endtask

  task automatic launch(input int n, input int wb, input int pb);
    cfg_n_layers    = 4'(n);
    cfg_base_weight = 20'(wb);
    cfg_base_param  = 12'(pb);
    start           = 1'b1;
  endtask

  // Plays the accelerator: acks each request after ack_delay extra cycles and
  // pulses layer_done done_delay cycles into WAIT (negative: never).
  task automatic serve_run(input int ack_delay, input int done_delay, input bit abort_cfg,
                           input bit poke_busy, input bit stray_done, input int max_cycles);
    int req_len, ack_obs, done_at;
    bit in_req, aborted, poked;
    logic [1:0]  hold_addr;
    logic [31:0] hold_data;
    wr_cnt = 0; done_pulses = 0; seq_obs = -1; unstable = 0; gap_viol = 0;
    req_len_min = 1000; req_len_max = 0; req_obs_total = 0; wait_entry_obs = -1;
    err_obs = -1; busy_low_obs = -1; last_done_obs = -1; post_req = 1'b0; post_busy = 1'b0;
    err_obs1 = 1'b0; timed_out = 1'b1;
    req_len = 0; ack_obs = -10; done_at = -1; in_req = 1'b0; aborted = 1'b0; poked = 1'b0;
    hold_addr = '0; hold_data = '0;
    for (int obs = 1; obs <= max_cycles; obs++) begin
      @(posedge HCLK);
      #1;
      start = 1'b0; reg_ack = 1'b0; layer_done = 1'b0; cfg_we = 1'b0;
      if (abort) begin
        abort = 1'b0; post_req = reg_req; post_busy = busy;
      end
      if (obs == 1) err_obs1 = error;
      if (seq_done) begin
        done_pulses++;
        if (seq_obs < 0) seq_obs = obs;
      end
      if (error && err_obs < 0) err_obs = obs;
      if (!busy && busy_low_obs < 0) busy_low_obs = obs;
      if (reg_req) begin
        req_obs_total++;
        if (obs == ack_obs + 1) gap_viol++;
        if (!in_req) begin
          in_req = 1'b1; req_len = 0; hold_addr = reg_addr; hold_data = reg_wdata;
        end else if (reg_addr !== hold_addr || reg_wdata !== hold_data) begin
          unstable++;
        end
        req_len++;
        if (stray_done && wr_cnt == 0 && req_len == 1) layer_done = 1'b1;
        if (abort_cfg && !aborted && reg_addr == 2'd1) begin
          abort = 1'b1; aborted = 1'b1;
        end else if (req_len == ack_delay + 1) begin
          reg_ack = 1'b1; ack_obs = obs; in_req = 1'b0;
          if (wr_cnt < 64) begin
            wr_addr[wr_cnt] = reg_addr; wr_data[wr_cnt] = reg_wdata;
          end
          wr_cnt++;
          if (req_len < req_len_min) req_len_min = req_len;
          if (req_len > req_len_max) req_len_max = req_len;
          if (reg_addr == 2'd2 && reg_wdata == 32'd0) begin
            wait_entry_obs = obs + 1;
            if (done_delay >= 0) done_at = obs + 1 + done_delay;
          end
        end
      end
      if (obs == done_at) begin
        layer_done = 1'b1; last_done_obs = obs;
      end
      if (poke_busy && !poked && obs == wait_entry_obs) begin
        start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_wdata = 9'h1FF; poked = 1'b1;
      end
      if (!busy && !seq_done && !abort) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0; cfg_we = 1'b0; reg_ack = 1'b0; layer_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [42:0] outs;
    HRESETn = 1'b0;
    tick(2);
    outs = {reg_req, reg_addr, reg_wdata, busy, cur_layer, seq_done, error};
    n_vec++;
    if (outs !== 43'd0) begin
      n_miss++; $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    end
    HRESETn = 1'b1;
    tick(2);
    n_vec++;
    if (busy !== 1'b0 || reg_req !== 1'b0) begin
      n_miss++; $display("[TB] FAIL idle_after_reset: busy=%b req=%b expected 0/0", busy, reg_req);
    end
  endtask

  task automatic test_three_layer();
    logic [33:0] exp_wr [12] = '{
      {2'd0, 32'h00000000}, {2'd1, 32'h0000E901}, {2'd2, 32'd1}, {2'd2, 32'd0},
      {2'd0, 32'h01000010}, {2'd1, 32'h0000F114}, {2'd2, 32'd1}, {2'd2, 32'd0},
      {2'd0, 32'h020000A0}, {2'd1, 32'h0000F12E}, {2'd2, 32'd1}, {2'd2, 32'd0}};
    load_desc(0, 9, 7, 1'b0);
    load_desc(1, 17, 7, 1'b1);
    load_desc(2, 17, 7, 1'b1);
    launch(3, 0, 0);
    serve_run(1, 2, 1'b0, 1'b0, 1'b1, 400);
    n_vec++;
    if (timed_out || wr_cnt != 12) begin
      n_miss++; $display("[TB] FAIL three_layer_writes: got %0d writes (timeout=%0d) expected 12", wr_cnt, timed_out);
    end
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      if ({wr_addr[i], wr_data[i]} !== exp_wr[i]) begin
        n_miss++; $display("[TB] FAIL three_layer_wr%0d: got %0d:%h expected %0d:%h",
                           i, wr_addr[i], wr_data[i], exp_wr[i][33:32], exp_wr[i][31:0]);
      end
    end
    n_vec++;
    if (done_pulses != 1 || seq_obs != last_done_obs + 2) begin
      n_miss++; $display("[TB] FAIL three_layer_seq_done: got %0d pulses at %0d expected 1 at %0d",
                         done_pulses, seq_obs, last_done_obs + 2);
    end
    n_vec++;
    if (gap_viol != 0 || unstable != 0) begin
      n_miss++; $display("[TB] FAIL three_layer_handshake: got gap=%0d unstable=%0d expected 0/0", gap_viol, unstable);
    end
    n_vec++;
    if (error !== 1'b0) begin
      n_miss++; $display("[TB] FAIL three_layer_error: got %b expected 0", error);
    end
  endtask

  task automatic test_zero_layers();
    launch(0, 5, 5);
    serve_run(0, 0, 1'b0, 1'b0, 1'b0, 20);
    n_vec++;
    if (timed_out || done_pulses != 1 || seq_obs < 1 || seq_obs > 2) begin
      n_miss++; $display("[TB] FAIL zero_layers_done: got %0d pulses at %0d expected 1 within 2", done_pulses, seq_obs);
    end
    n_vec++;
    if (req_obs_total != 0) begin
      n_miss++; $display("[TB] FAIL zero_layers_req: got %0d req cycles expected 0", req_obs_total);
    end
    n_vec++;
    if (error !== 1'b0 || err_obs != -1) begin
      n_miss++; $display("[TB] FAIL zero_layers_error: got %b expected 0", error);
    end
  endtask

  task automatic test_bad_count();
    launch(9, 0, 0);
    serve_run(0, 0, 1'b0, 1'b0, 1'b0, 20);
    n_vec++;
    if (error !== 1'b1 || err_obs != 1) begin
      n_miss++; $display("[TB] FAIL bad_count_error: got %b (first at %0d) expected 1 at 1", error, err_obs);
    end
    n_vec++;
    if (timed_out || busy_low_obs < 1 || busy_low_obs > 2) begin
      n_miss++; $display("[TB] FAIL bad_count_busy: busy low at %0d expected within 2", busy_low_obs);
    end
    n_vec++;
    if (req_obs_total != 0 || done_pulses != 0) begin
      n_miss++; $display("[TB] FAIL bad_count_activity: got req=%0d done=%0d expected 0/0", req_obs_total, done_pulses);
    end
  endtask

  task automatic test_timeout();
    launch(1, 0, 0);
    serve_run(0, -1, 1'b0, 1'b0, 1'b0, 200);
    n_vec++;
    if (timed_out || wait_entry_obs < 0 || err_obs - wait_entry_obs != 16) begin
      n_miss++; $display("[TB] FAIL timeout_latency: got %0d cycles in WAIT expected 16", err_obs - wait_entry_obs);
    end
    n_vec++;
    if (err_obs1 !== 1'b0) begin
      n_miss++; $display("[TB] FAIL timeout_start_clear: got %b expected 0", err_obs1);
    end
    n_vec++;
    if (done_pulses != 0) begin
      n_miss++; $display("[TB] FAIL timeout_seq_done: got %0d expected 0", done_pulses);
    end
    tick(4);
    n_vec++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      n_miss++; $display("[TB] FAIL timeout_sticky: got error=%b busy=%b expected 1/0", error, busy);
    end
    launch(0, 0, 0);
    serve_run(0, 0, 1'b0, 1'b0, 1'b0, 20);
    n_vec++;
    if (err_obs1 !== 1'b0 || error !== 1'b0) begin
      n_miss++; $display("[TB] FAIL timeout_clear_on_start: got %b/%b expected 0/0", err_obs1, error);
    end
  endtask

  task automatic test_slow_ack_wrap();
    logic [33:0] exp_wr [8] = '{
      {2'd0, 32'hFF8FFFF8}, {2'd1, 32'h0000F105}, {2'd2, 32'd1}, {2'd2, 32'd0},
      {2'd0, 32'h00800088}, {2'd1, 32'h0000F11E}, {2'd2, 32'd1}, {2'd2, 32'd0}};
    load_desc(0, 17, 7, 1'b1);
    launch(2, 20'hFFFF8, 12'hFF8);
    serve_run(5, 1, 1'b0, 1'b0, 1'b0, 400);
    n_vec++;
    if (timed_out || wr_cnt != 8) begin
      n_miss++; $display("[TB] FAIL slow_ack_writes: got %0d writes expected 8", wr_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if ({wr_addr[i], wr_data[i]} !== exp_wr[i]) begin
        n_miss++; $display("[TB] FAIL slow_ack_wr%0d: got %0d:%h expected %0d:%h",
                           i, wr_addr[i], wr_data[i], exp_wr[i][33:32], exp_wr[i][31:0]);
      end
    end
    n_vec++;
    if (unstable != 0 || req_len_min != 6 || req_len_max != 6) begin
      n_miss++; $display("[TB] FAIL slow_ack_stable: got unstable=%0d len=%0d..%0d expected 0 and 6",
                         unstable, req_len_min, req_len_max);
    end
    n_vec++;
    if (done_pulses != 1) begin
      n_miss++; $display("[TB] FAIL slow_ack_done: got %0d expected 1", done_pulses);
    end
  endtask

  task automatic test_abort();
    launch(3, 0, 0);
    serve_run(0, 0, 1'b1, 1'b0, 1'b0, 100);
    n_vec++;
    if (timed_out || post_req !== 1'b0 || post_busy !== 1'b0) begin
      n_miss++; $display("[TB] FAIL abort_cfg: got req=%b busy=%b expected 0/0", post_req, post_busy);
    end
    n_vec++;
    if (done_pulses != 0 || error !== 1'b0 || wr_cnt != 1) begin
      n_miss++; $display("[TB] FAIL abort_side_effects: got done=%0d error=%b writes=%0d expected 0/0/1",
                         done_pulses, error, wr_cnt);
    end
    cfg_n_layers = 4'd1;
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(1);
    n_vec++;
    if (busy !== 1'b0 || reg_req !== 1'b0 || seq_done !== 1'b0) begin
      n_miss++; $display("[TB] FAIL abort_start_idle: got busy=%b req=%b done=%b expected 0/0/0", busy, reg_req, seq_done);
    end
  endtask

  task automatic test_back_to_back();
    load_desc(0, 9, 7, 1'b0);
    launch(1, 0, 0);
    serve_run(0, 3, 1'b0, 1'b1, 1'b0, 200);
    n_vec++;
    if (timed_out || done_pulses != 1 || wr_cnt != 4) begin
      n_miss++; $display("[TB] FAIL busy_ignore_run: got done=%0d writes=%0d expected 1/4", done_pulses, wr_cnt);
    end
    launch(1, 0, 0);
    serve_run(0, 0, 1'b0, 1'b0, 1'b0, 200);
    n_vec++;
    if (wr_cnt != 4 || wr_data[1] !== 32'h0000E90B) begin
      n_miss++; $display("[TB] FAIL busy_ignore_desc: got cfg=%h expected 0000e90b", wr_data[1]);
    end
  endtask

  task automatic test_reset_mid_run();
    launch(3, 7, 7);
    tick(1);
    start = 1'b0;
    tick(4);
    HRESETn = 1'b0;
    tick(1);
    n_vec++;
    if ({reg_req, reg_addr, reg_wdata, busy, cur_layer, seq_done, error} !== 43'd0) begin
      n_miss++; $display("[TB] FAIL reset_mid_run: got req=%b busy=%b data=%h expected all 0", reg_req, busy, reg_wdata);
    end
    HRESETn = 1'b1;
    tick(2);
  endtask

  initial begin
    HRESETn = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_wdata = '0; cfg_n_layers = '0;
    cfg_base_weight = '0; cfg_base_param = '0; start = 1'b0; abort = 1'b0;
    reg_ack = 1'b0; layer_done = 1'b0;
    tick(1);
    test_reset();
    test_three_layer();
    test_zero_layers();
    test_bad_count();
    test_timeout();
    test_slow_ack_wrap();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
Hardware layer sequencer for the CNN accelerator. It replaces the CPU's per-layer program/start/poll loop with a descriptor-driven state machine. A table of up to N_LAYER_MAX layer descriptors is loaded once. After one start pulse, the block performs these steps for every layer in turn:
- writes BASE_ADDRESS, LAYER_CONFIG, LAYER_START=1 and LAYER_START=0 to the accelerator register port;
- waits for the accelerator's layer_done, with a timeout;
- advances the weight and parameter base addresses.

Parameters:
N_LAYER_MAX, 8, descriptor table depth (max layers per run)
W_LIDX, $clog2(N_LAYER_MAX), layer index width
Ti, 16, input-channel parallelism
To, 16, output-channel parallelism
N, 16, weights per weight-memory word
W_BASE_W, 20, weight base address width
W_BASE_P, 12, param base address width
W_RADDR, 2, accelerator register index width
TIMEOUT_CYCLES, 1000000, wait-for-done limit; 0 disables the timeout
W_TO, 24, timeout counter width

Ports:
HCLK  in  1  clock
HRESETn  in  1  synchronous active-low reset
cfg_we  in  1  descriptor write strobe; ignored while busy
cfg_idx  in  W_LIDX  descriptor index
cfg_wdata  in  9  {is_conv3x3, bias_shift[4:0], act_shift[2:0]}
cfg_n_layers  in  W_LIDX+1  number of layers to run
cfg_base_weight  in  W_BASE_W  initial weight base
cfg_base_param  in  W_BASE_P  initial param base
start  in  1  run pulse; ignored while busy
abort  in  1  cancel the run
reg_req  out  1  register write request
reg_addr  out  W_RADDR  register index: 0 BASE_ADDRESS, 1 LAYER_CONFIG, 2 LAYER_START
reg_wdata  out  32  register write data
reg_ack  in  1  write accepted
layer_done  in  1  accelerator layer-done flag
busy  out  1  run in progress
cur_layer  out  W_LIDX  index of the layer being processed
seq_done  out  1  one-cycle pulse when a run completes
error  out  1  sticky flag: timeout or bad layer count

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, base registers 0. The descriptor table is not reset.
- FSM states: IDLE, WR_BASE, WR_CFG, WR_ST1, WR_ST0, WAIT, ADV, FIN, ERR.
- IDLE, on start:
  - error is cleared;
  - the base registers load from the cfg_* inputs;
  - cur_layer is set to 0.
  - If cfg_n_layers == 0: go to FIN (no writes).
  - If cfg_n_layers > N_LAYER_MAX: go to ERR.
  - Otherwise go to WR_BASE.
- Register write handshake (all WR_* states):
  - reg_req is asserted; reg_addr and reg_wdata stay stable until the cycle reg_ack is sampled high.
  - reg_req is 0 on the cycle after the ack.
  - The next request starts no earlier than 2 cycles after the previous ack.
  - reg_ack while reg_req=0 is ignored.
- Write data per state:
  - WR_BASE: reg_wdata = {param_base, weight_base}, zero-extended to 32 bits.
  - WR_CFG: reg_wdata = zero-extended 16-bit word {act_shift[2:0], bias_shift[4:0], cur_layer[3:0], is_last, is_conv3x3, is_last, is_first}.
  - is_first = (cur_layer == 0); is_last = (cur_layer == cfg_n_layers-1). cfg_n_layers is latched at start.
  - WR_ST1 writes 1, then WR_ST0 writes 0, both to register 2.
- WAIT:
  - Clears then increments the timeout counter each cycle.
  - layer_done high goes to ADV.
  - If the counter reaches TIMEOUT_CYCLES-1 with layer_done low, go to ERR.
  - layer_done is ignored in every state other than WAIT.
- ADV (1 cycle):
  - Conv3x3 layer: weight_base += Ti*To*9/N.
  - Other layers: weight_base += To.
  - param_base += To in both cases; both additions wrap modulo their width.
  - If is_last, go to FIN; otherwise cur_layer++ and go to WR_BASE.
- FIN: seq_done=1 for one cycle, then IDLE. busy=0 only in IDLE and FIN.
- ERR: error=1, then IDLE next cycle. error stays sticky until the next accepted start.
- abort in any non-IDLE state:
  - go to IDLE on the next cycle;
  - reg_req drops, even mid-handshake;
  - seq_done and error are not asserted.
- abort has priority over reg_ack and layer_done in the same cycle.
- start together with abort while IDLE: abort wins, the start is ignored.
- Reset mid-run returns the FSM to IDLE with all outputs at their reset values.

Decomposition:
- Shared package cnn_seq_pkg holds:
  - FSM state enum;
  - register index constants REG_BASE_ADDRESS=0, REG_LAYER_CONFIG=1, REG_LAYER_START=2;
  - descriptor field offsets;
  - the weight-step function Ti*To*9/N.
- One sub-module: cnn_seq_desc_ram, an N_LAYER_MAX x 9 register-file descriptor table with a synchronous write port and a combinational read port.

Test Plan:
- 3-layer run, Ti=To=N=16, bases 0/0, descriptors (bias,act,3x3) = (9,7,0), (17,7,1), (17,7,1), reg_ack 1 cycle after each req -> BASE writes 0x00000000, 0x01000010, 0x020000A0; CONFIG writes 0xE901, 0xF114, 0xF12E; START 1 then 0 per layer; exactly one seq_done pulse after the 3rd layer_done.
- cfg_n_layers=0 -> seq_done pulses 2 cycles after start, no reg_req, error=0.
- cfg_n_layers=N_LAYER_MAX+1 -> error=1, no reg_req, busy low again within 2 cycles.
- TIMEOUT_CYCLES=16 with layer_done held 0 -> ERR reached 16 cycles after entering WAIT; error stays 1 until the next start, which clears it.
- reg_ack delayed 5 cycles -> reg_addr and reg_wdata stable for all 6 request cycles. Also: abort during WR_CFG -> reg_req 0 next cycle, busy 0, no seq_done.
- Start while busy and cfg_we while busy are both ignored -> the descriptor read back after the run is unchanged and only one run occurs.
